// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the shared-mux arbiter, its requesters,
// the 8-input mux and the downstream result bus.
`ifndef DATA_W
`define DATA_W 32
`endif

interface mux_rr_arbiter_if #(
   parameter int DATA_W = `DATA_W
) ();
   logic [7:0]        req;
   logic [DATA_W-1:0] mux_o;
   logic [3:0]        sel;
   logic [7:0]        grant;
   logic [DATA_W-1:0] out_data;
   logic [2:0]        out_src;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport master (
      output req, mux_o, out_ready,
      input  sel, grant, out_data, out_src,
      input  out_valid, busy
   );

   modport slave (
      input  req, mux_o, out_ready,
      output sel, grant, out_data, out_src,
      output out_valid, busy
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 8-input mux with registered output.
// Define MUXARB_PRIO_EN for fixed priority (req[0] highest).
`ifndef DATA_W
`define DATA_W 32
`endif

module mux_rr_arbiter #(
   parameter int DATA_W = `DATA_W,
   parameter int N_REQ  = 8
) (
   input logic             clk,
   input logic             rst,
   mux_rr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      HOLD
   } state_t;

   state_t            state, nxt;
   logic [2:0]        sel_q;
   logic [2:0]        win;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        src_q;
   logic              valid_q;
   logic              arb, cap, drop;

`ifdef MUXARB_PRIO_EN
   always_comb begin
      win = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req[k]) win = 3'(k);
      end
   end
`else
   logic [2:0] ptr;
   logic [2:0] idx;
   logic       found;

   // Scan starts just past the last winner, so it ends up lowest priority.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ptr + 3'(k);
         if (!found && bus.req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt  = state;
      arb  = 1'b0;
      cap  = 1'b0;
      drop = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               arb = 1'b1;
               nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            cap = 1'b1;
            nxt = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               drop = 1'b1;
               if (|bus.req) begin
                  arb = 1'b1;
                  nxt = CAPTURE;
               end else begin
                  nxt = IDLE;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
`ifndef MUXARB_PRIO_EN
         ptr     <= 3'd7;
`endif
      end else begin
         if (arb) sel_q <= win;
         if (cap) begin
            data_q  <= bus.mux_o;
            src_q   <= sel_q;
            valid_q <= 1'b1;
`ifndef MUXARB_PRIO_EN
            ptr     <= sel_q;
`endif
         end else if (drop) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.sel       = {1'b0, sel_q};
   assign bus.grant     = (state == CAPTURE) ? (8'd1 << sel_q) : 8'd0;
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;
   assign bus.out_valid = valid_q;
   assign bus.busy      = (state != IDLE);

endmodule
